// File: rtl/emu_clk_pll_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : emu_clk_pll_pkg
//  Brief    : Shared types, default constants and ratio check for the
//             multi-channel emulation PLL.
//  Revision : 1.0 - initial release
// ============================================================================
package emu_clk_pll_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } pll_state_e;

    localparam int c_def_num_ch  = 4;
    localparam int c_def_ratio_w = 16;
    localparam int c_def_lock_w  = 16;

    // Arguments are zero-extended by the caller so one function serves any RATIO_W <= 32.
    function automatic logic ratio_illegal(input logic [31:0] num, input logic [31:0] den);
        return (den == 32'd0) || (num == 32'd0) || (num > den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/emu_clk_pll_chan.sv
`default_nettype none
// ============================================================================
//  Module   : emu_clk_pll_chan
//  Brief    : One fractional-ratio clock channel: phase accumulator, lock FSM,
//             lock counter and shadow ratio. EMU_CLK_PLL_GLITCHFREE_EN defers
//             disable/relock until clk_out falls.
//  Revision : 1.0 - initial release
// ============================================================================
module emu_clk_pll_chan
    import emu_clk_pll_pkg::*;
#(
    parameter int RATIO_W = c_def_ratio_w,
    parameter int LOCK_W  = c_def_lock_w
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [RATIO_W-1:0] num,
    input  logic [RATIO_W-1:0] den,
    input  logic [LOCK_W-1:0]  lock_delay,
    output logic               clk_out,
    output logic               lock,
    output logic               cfg_err
);

`ifdef EMU_CLK_PLL_GLITCHFREE_EN
    localparam bit c_glitchfree = 1'b1;
`else
    localparam bit c_glitchfree = 1'b0;
`endif

    pll_state_e         r_state;
    logic [RATIO_W:0]   r_acc;
    logic [RATIO_W-1:0] r_num_sh;
    logic [RATIO_W-1:0] r_den_sh;
    logic [LOCK_W-1:0]  r_cnt;
    logic               r_clk_out;
    logic               r_lock;
    logic               r_cfg_err;

    logic [RATIO_W:0]   w_sum;
    logic [RATIO_W:0]   w_acc_next;
    logic               w_toggle;
    logic               w_err;
    logic               w_stop;
    logic               w_change;
    logic               w_hold;

    always_comb begin
        w_sum      = r_acc + {1'b0, r_num_sh};
        w_toggle   = (w_sum >= {1'b0, r_den_sh});
        w_acc_next = w_toggle ? (w_sum - {1'b0, r_den_sh}) : w_sum;
        w_err      = ratio_illegal(32'(num), 32'(den));
        w_stop     = !enable || w_err;
        w_change   = (num != r_num_sh) || (den != r_den_sh);
        // A low clk_out cannot be truncated, so only a high phase without a falling edge defers.
        w_hold     = c_glitchfree && r_clk_out && !w_toggle;
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_state   <= OFF;
            r_acc     <= '0;
            r_num_sh  <= '0;
            r_den_sh  <= '0;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_lock    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_err;
            case (r_state)
                OFF: begin
                    r_acc     <= '0;
                    r_clk_out <= 1'b0;
                    r_lock    <= 1'b0;
                    if (!w_stop) begin
                        r_state  <= LOCKING;
                        r_num_sh <= num;
                        r_den_sh <= den;
                        r_cnt    <= lock_delay;
                    end
                end
                default: begin
                    if (w_stop && !w_hold) begin
                        r_state   <= OFF;
                        r_acc     <= '0;
                        r_clk_out <= 1'b0;
                        r_lock    <= 1'b0;
                    end else if (w_stop) begin
                        r_acc     <= w_acc_next;
                        r_clk_out <= r_clk_out ^ w_toggle;
                        r_lock    <= 1'b0;
                    end else if (w_change && !w_hold) begin
                        r_state   <= LOCKING;
                        r_num_sh  <= num;
                        r_den_sh  <= den;
                        r_cnt     <= lock_delay;
                        r_acc     <= '0;
                        r_lock    <= 1'b0;
                        r_clk_out <= c_glitchfree ? 1'b0 : r_clk_out;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_clk_out <= r_clk_out ^ w_toggle;
                        if (r_state == LOCKING) begin
                            if (r_cnt == '0) begin
                                r_state <= LOCKED;
                                r_lock  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign clk_out = r_clk_out;
    assign lock    = r_lock;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: rtl/emu_clk_pll_nch.sv
`default_nettype none
// ============================================================================
//  Module   : emu_clk_pll_nch
//  Brief    : NUM_CH independent fractional-ratio emulation clocks from one
//             reference clock. Optional macro: EMU_CLK_PLL_GLITCHFREE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module emu_clk_pll_nch
    import emu_clk_pll_pkg::*;
#(
    parameter int NUM_CH  = c_def_num_ch,
    parameter int RATIO_W = c_def_ratio_w,
    parameter int LOCK_W  = c_def_lock_w
) (
    input  logic                      ref_clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH*RATIO_W-1:0] numerator,
    input  logic [NUM_CH*RATIO_W-1:0] denominator,
    input  logic [LOCK_W-1:0]         lock_delay,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         lock,
    output logic [NUM_CH-1:0]         cfg_err
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        emu_clk_pll_chan #(
            .RATIO_W (RATIO_W),
            .LOCK_W  (LOCK_W)
        ) u_chan (
            .ref_clk    (ref_clk),
            .rst        (rst),
            .enable     (enable[gi]),
            .num        (numerator[gi*RATIO_W +: RATIO_W]),
            .den        (denominator[gi*RATIO_W +: RATIO_W]),
            .lock_delay (lock_delay),
            .clk_out    (clk_out[gi]),
            .lock       (lock[gi]),
            .cfg_err    (cfg_err[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_emu_clk_pll_nch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_emu_clk_pll_nch
//  Brief    : Scoreboard bench for emu_clk_pll_nch; expectations are queued
//             per ref_clk cycle and compared by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_emu_clk_pll_nch;

    localparam int NCH = 4;
    localparam int RW  = 16;
    localparam int LW  = 16;

    logic                ref_clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      enable;
    logic [NCH*RW-1:0]   numerator;
    logic [NCH*RW-1:0]   denominator;
    logic [LW-1:0]       lock_delay;
    logic [NCH-1:0]      clk_out;
    logic [NCH-1:0]      lock;
    logic [NCH-1:0]      cfg_err;

    emu_clk_pll_nch #(
        .NUM_CH  (NCH),
        .RATIO_W (RW),
        .LOCK_W  (LW)
    ) dut (
        .ref_clk     (ref_clk),
        .rst         (rst),
        .enable      (enable),
        .numerator   (numerator),
        .denominator (denominator),
        .lock_delay  (lock_delay),
        .clk_out     (clk_out),
        .lock        (lock),
        .cfg_err     (cfg_err)
    );

    always #5 ref_clk = ~ref_clk;

    // cyc equals the number of ref_clk rising edges seen so far
    int cyc = 0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    typedef struct {
        int    at;
        int    ch;
        int    sig;
        logic  val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input int at, input int ch, input int sig, input logic val, input string name);
        exp_t e;
        e.at = at; e.ch = ch; e.sig = sig; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    // Phase-accumulator clock: after j accumulating edges clk_out has toggled floor(j*a/b) times.
    task automatic push_run(input int ch, input int a, input int b, input int start, input int n, input logic init);
        for (int j = 0; j < n; j++)
            push(start + j, ch, 0, init ^ logic'(((j * a) / b) % 2), $sformatf("clk_%0d_%0d", a, b));
    endtask

    task automatic set_ratio(input int ch, input int a, input int b);
        numerator[ch*RW +: RW]   = 16'(a);
        denominator[ch*RW +: RW] = 16'(b);
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    function automatic logic pick(input int sig, input int ch);
        case (sig)
            0:       return clk_out[ch];
            1:       return lock[ch];
            default: return cfg_err[ch];
        endcase
    endfunction

    always @(negedge ref_clk) begin
        logic act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                act = pick(sb[i].sig, sb[i].ch);
                n_tests++;
                if (sb[i].at < cyc || act !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL ch%0d %s sig%0d @cyc %0d: got %b expected %b",
                             sb[i].ch, sb[i].name, sb[i].sig, sb[i].at, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        enable      = '0;
        numerator   = '0;
        denominator = '0;
        lock_delay  = 16'd3;
        for (int c = 0; c < NCH; c++) set_ratio(c, 1, 4);
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 3; s++) push(3, c, s, 1'b0, "reset");

        go(3);
        rst = 1'b0;

        // ch0 1/4, lock_delay 3: enable sampled at edge 10
        go(9);
        enable[0] = 1'b1;
        push(13, 0, 1, 1'b0, "lock_pre");
        push(14, 0, 1, 1'b1, "lock_rise");
        push(26, 0, 1, 1'b1, "lock_hold");
        push_run(0, 1, 4, 10, 17, 1'b0);

        // relock to 1/2 while clk_out is low
        go(26);
        n_tests++;
        if (lock[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ch0 direct_lock_26: got %b expected 1", lock[0]);
        end
        n_tests++;
        if (cfg_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ch0 direct_cfg_err_26: got %b expected 0", cfg_err[0]);
        end
        set_ratio(0, 1, 2);
        push(27, 0, 1, 1'b0, "relock_drop");
        push(30, 0, 1, 1'b0, "relock_wait");
        push(31, 0, 1, 1'b1, "relock_rise");
        push_run(0, 1, 2, 27, 18, 1'b0);

        // num > den
        go(44);
        n_tests++;
        if (lock[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ch0 direct_lock_44: got %b expected 1", lock[0]);
        end
        set_ratio(0, 5, 4);
        push(45, 0, 2, 1'b1, "err_num_gt_den");
        push(45, 0, 1, 1'b0, "err_lock");
        push(45, 0, 0, 1'b0, "err_clk");
        push(46, 0, 0, 1'b0, "err_clk_off");
        push(46, 0, 2, 1'b1, "err_hold");

        // den == 0
        go(46);
        n_tests++;
        if (cfg_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ch0 direct_cfg_err_46: got %b expected 1", cfg_err[0]);
        end
        n_tests++;
        if (clk_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ch0 direct_clk_46: got %b expected 0", clk_out[0]);
        end
        n_tests++;
        if (lock[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ch0 direct_lock_46: got %b expected 0", lock[0]);
        end
        set_ratio(0, 1, 0);
        push(47, 0, 2, 1'b1, "err_den_zero");
        push(47, 0, 0, 1'b0, "err_den_clk");

        // restore 1/4, relock from OFF
        go(48);
        set_ratio(0, 1, 4);
        push(49, 0, 2, 1'b0, "err_clear");
        push(52, 0, 1, 1'b0, "restore_wait");
        push(53, 0, 1, 1'b1, "restore_lock");
        push_run(0, 1, 4, 49, 42, 1'b0);

        // staggered channels with lock_delay 0
        go(56);
        lock_delay = 16'd0;
        go(58);
        set_ratio(1, 1, 1);
        enable[1] = 1'b1;
        push(59, 1, 1, 1'b0, "d0_lock_pre");
        push(60, 1, 1, 1'b1, "d0_lock");
        push_run(1, 1, 1, 59, 32, 1'b0);
        go(61);
        set_ratio(2, 1, 2);
        enable[2] = 1'b1;
        push(62, 2, 1, 1'b0, "d0_lock_pre");
        push(63, 2, 1, 1'b1, "d0_lock");
        push_run(2, 1, 2, 62, 29, 1'b0);
        go(63);
        set_ratio(3, 2, 5);
        enable[3] = 1'b1;
        push(64, 3, 1, 1'b0, "d0_lock_pre");
        push(65, 3, 1, 1'b1, "d0_lock");
        push(70, 3, 2, 1'b0, "legal_no_err");
        push_run(3, 2, 5, 64, 27, 1'b0);

        // reset with all channels locked
        go(90);
        rst = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 3; s++) push(91, c, s, 1'b0, "reset_mid");
        go(91);
        n_tests++;
        if (clk_out !== '0) begin
            n_fail++;
            $display("FAIL direct_reset_clk: got %b expected 0", clk_out);
        end
        n_tests++;
        if (lock !== '0) begin
            n_fail++;
            $display("FAIL direct_reset_lock: got %b expected 0", lock);
        end
        n_tests++;
        if (cfg_err !== '0) begin
            n_fail++;
            $display("FAIL direct_reset_cfg_err: got %b expected 0", cfg_err);
        end
        rst    = 1'b0;
        enable = '0;

        // ch3 3/8: 6 toggles per 16 cycles; ch2 1/4 then disabled inside a high phase
        go(94);
        set_ratio(3, 3, 8);
        set_ratio(2, 1, 4);
        enable[3] = 1'b1;
        enable[2] = 1'b1;
        push(96, 3, 1, 1'b1, "r38_lock");
        push(110, 3, 1, 1'b1, "r38_lock_hold");
        push_run(3, 3, 8, 95, 16, 1'b0);
        push(96, 2, 1, 1'b1, "dis_lock");
        push_run(2, 1, 4, 95, 6, 1'b0);
        go(100);
        enable[2] = 1'b0;
        push(101, 2, 1, 1'b0, "dis_lock_drop");
`ifdef EMU_CLK_PLL_GLITCHFREE_EN
        push(101, 2, 0, 1'b1, "gf_hold_high");
        push(102, 2, 0, 1'b1, "gf_hold_high");
        push(103, 2, 0, 1'b0, "gf_fall");
        push(104, 2, 0, 1'b0, "gf_off");
`else
        push(101, 2, 0, 1'b0, "dis_truncate");
        push(102, 2, 0, 1'b0, "dis_off");
`endif

        go(112);
        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL ch%0d %s never checked @cyc %0d: got none expected %b",
                     sb[i].ch, sb[i].name, sb[i].at, sb[i].val);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
